micro_sim_top: RTL and testbench

//  Top of the 2D-convolution engine as driven by a soft-CPU 32-bit GPIO word. Decodes

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/conv_mac.sv | 93 +++++++++
 rtl/micro_sim_top.sv | 238 +++++++++++++++++++++++
 tb/tb_micro_sim_top.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, GPIO command-word layout, opcodes and FSM state type
// for the GPIO-driven 3x3 convolution engine.
package conv_pkg;

  localparam int BIT_LEN    = 8;
  localparam int CONV_LEN   = 20;
  localparam int CONV_LPOS  = 13;
  localparam int M_LEN      = 3;
  localparam int NB_ADDRESS = 10;
  localparam int RAM_WIDTH  = 13;
  localparam int GPIO_D     = 32;

  // One image/kernel column is M_LEN pixels; a window is M_LEN columns.
  localparam int COL_W      = M_LEN * BIT_LEN;
  localparam int WIN_W      = M_LEN * COL_W;
  localparam int RAM_DEPTH  = 1 << NB_ADDRESS;

  localparam logic [NB_ADDRESS-1:0] ADDR_ONE  = NB_ADDRESS'(1);
  localparam logic [NB_ADDRESS-1:0] ADDR_MLEN = NB_ADDRESS'(M_LEN);

  localparam logic [2:0] OP_KLOAD = 3'b000;
  localparam logic [2:0] OP_SIZE  = 3'b001;
  localparam logic [2:0] OP_ILOAD = 3'b010;
  localparam logic [2:0] OP_DREQ  = 3'b011;
  localparam logic [2:0] OP_RUN   = 3'b100;

  localparam int GPIO_OP_MSB = 31;
  localparam int GPIO_OP_LSB = 29;
  localparam int GPIO_VALID  = 28;
  localparam int GPIO_PL_MSB = 24;
  localparam int GPIO_PL_LSB = 1;
  localparam int GPIO_SRST   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// conv_mac: M_LEN x M_LEN multiply-accumulate (signed kernel, unsigned pixels)
// with a registered result holding the CONV_LPOS MSBs of the CONV_LEN accumulator.
// Build option MICRO_SIM_SAT_EN: clip the accumulator to +/-(2^(CONV_LEN-1)-1)
// before dropping the low bits; otherwise the bits are simply truncated.
module conv_mac
  import conv_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_vld,
  input  logic [WIN_W-1:0]     i_kernel,
  input  logic [WIN_W-1:0]     i_window,
  output logic [CONV_LPOS-1:0] o_res,
  output logic                 o_vld
);

  // Two guard bits above CONV_LEN so the clip compare sees the true sum.
  localparam int SUM_W  = CONV_LEN + 2;
  localparam int PROD_W = 2 * BIT_LEN + 1;

  logic signed [SUM_W-1:0] w_sum;
  logic [CONV_LPOS-1:0]    w_res;
  logic                    w_unused;
  logic [CONV_LPOS-1:0]    r_res;
  logic                    r_vld;

  // Sum of products over the window; kernel taps sign-extended, pixels zero-extended.
  always_comb begin
    logic [BIT_LEN-1:0]       v_kb;
    logic signed [PROD_W-1:0] v_k;
    logic signed [PROD_W-1:0] v_p;
    logic signed [PROD_W-1:0] v_prod;
    w_sum  = '0;
    v_kb   = '0;
    v_k    = '0;
    v_p    = '0;
    v_prod = '0;
    for (int j = 0; j < M_LEN; j++) begin
      for (int i = 0; i < M_LEN; i++) begin
        v_kb   = i_kernel[(j*M_LEN+i)*BIT_LEN +: BIT_LEN];
        v_k    = {{(PROD_W-BIT_LEN){v_kb[BIT_LEN-1]}}, v_kb};
        v_p    = {{(PROD_W-BIT_LEN){1'b0}}, i_window[(j*M_LEN+i)*BIT_LEN +: BIT_LEN]};
        v_prod = v_k * v_p;
        w_sum  = w_sum + {{(SUM_W-PROD_W){v_prod[PROD_W-1]}}, v_prod};
      end
    end
  end

`ifdef MICRO_SIM_SAT_EN
  localparam logic signed [SUM_W-1:0] ACC_MAX =
    {{(SUM_W-CONV_LEN+1){1'b0}}, {(CONV_LEN-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = -ACC_MAX;

  logic signed [SUM_W-1:0] w_clip;

  // Symmetric clip of the full sum before the low bits are discarded.
  always_comb begin
    w_clip = w_sum;
    if (w_sum > ACC_MAX) begin
      w_clip = ACC_MAX;
    end else if (w_sum < ACC_MIN) begin
      w_clip = ACC_MIN;
    end
  end

  assign w_res    = w_clip[CONV_LEN-1 -: CONV_LPOS];
  assign w_unused = ^{w_clip[SUM_W-1:CONV_LEN], w_clip[CONV_LEN-CONV_LPOS-1:0]};
`else
  assign w_res    = w_sum[CONV_LEN-1 -: CONV_LPOS];
  assign w_unused = ^{w_sum[SUM_W-1:CONV_LEN], w_sum[CONV_LEN-CONV_LPOS-1:0]};
`endif

  // Output register: captures a result for every valid window.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res <= '0;
      r_vld <= 1'b0;
    end else if (i_clr) begin
      r_res <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= i_vld;
      if (i_vld) begin
        r_res <= w_res;
      end
    end
  end

  assign o_res = r_res;
  assign o_vld = r_vld;

endmodule

// File: rtl/micro_sim_top.sv
// micro_sim_top: GPIO-command front end of the 3x3 convolution engine. Decodes the
// synchronized command word, holds kernel/image/result storage, sequences the
// convolution and returns results on the readback word. o_led flags completion.
// Build option MICRO_SIM_SAT_EN (in conv_mac) selects saturating result rounding.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for opcode RUN with o_led low
// ST_RUN  | streaming image columns through the window and MAC
// ST_DONE | all results written, o_led set; leaves once opcode != RUN
module micro_sim_top
  import conv_pkg::*;
(
  input  logic              i_CLK,
  input  logic              i_rst_n,
  input  logic [GPIO_D-1:0] gpio_o_data_tri_o,
  output logic [GPIO_D-1:0] gpio_i_data_tri_i,
  output logic              o_led
);

  logic [GPIO_D-1:0]     r_gpio_s1;
  logic [GPIO_D-1:0]     r_gpio_s2;
  logic                  r_valid_d;
  logic [2:0]            w_op;
  logic                  w_strobe;
  logic                  w_srst;
  logic                  w_cmd;
  logic                  w_busy;
  logic [COL_W-1:0]      w_payload;
  logic                  w_unused;

  logic [WIN_W-1:0]      r_kernel;
  logic [1:0]            r_kptr;
  logic [NB_ADDRESS-1:0] r_img_len;
  logic [NB_ADDRESS-1:0] r_wptr;
  logic [NB_ADDRESS-1:0] r_rptr;
  logic [NB_ADDRESS-1:0] w_last_idx;
  logic                  r_led;
  logic [GPIO_D-1:0]     r_gpio_i;

  conv_state_t           r_state;
  conv_state_t           w_state_nxt;
  logic                  w_rd_en;
  logic                  w_set_led;

  logic [NB_ADDRESS-1:0] r_rd_idx;
  logic [NB_ADDRESS-1:0] r_wr_idx;
  logic                  r_rd_vld;
  logic                  r_win_vld;
  logic [1:0]            r_fill;
  logic [COL_W-1:0]      r_rd_data;
  logic [WIN_W-1:0]      r_window;
  logic [CONV_LPOS-1:0]  w_mac_res;
  logic                  w_mac_vld;

  logic [COL_W-1:0]      r_img_ram [0:RAM_DEPTH-1];
  logic [RAM_WIDTH-1:0]  r_res_ram [0:RAM_DEPTH-1];

  // Two-flop synchronizer for the whole command word plus valid-edge history.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gpio_s1 <= '0;
      r_gpio_s2 <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_gpio_s1 <= gpio_o_data_tri_o;
      r_gpio_s2 <= r_gpio_s1;
      r_valid_d <= r_gpio_s2[GPIO_VALID];
    end
  end

  assign w_op       = r_gpio_s2[GPIO_OP_MSB:GPIO_OP_LSB];
  assign w_payload  = r_gpio_s2[GPIO_PL_MSB:GPIO_PL_LSB];
  assign w_srst     = r_gpio_s2[GPIO_SRST];
  assign w_strobe   = r_gpio_s2[GPIO_VALID] & ~r_valid_d;
  assign w_cmd      = w_strobe & ~w_srst;
  assign w_busy     = (r_state == ST_RUN);
  assign w_last_idx = r_img_len - ADDR_MLEN;
  assign w_unused   = ^r_gpio_s2[GPIO_VALID-1:GPIO_PL_MSB+1];

  // FSM state register; soft reset forces IDLE.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else if (w_srst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state, column-read enable and completion flag.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_set_led   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op == OP_RUN && !r_led) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_img_len < ADDR_MLEN) begin
          w_state_nxt = ST_DONE;
          w_set_led   = 1'b1;
        end else begin
          w_rd_en = (r_rd_idx != r_img_len);
          if (w_mac_vld && r_wr_idx == w_last_idx) begin
            w_state_nxt = ST_DONE;
            w_set_led   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (w_op != OP_RUN) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command decode: kernel/size/pointer registers, completion flag and readback word.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kernel  <= '0;
      r_kptr    <= '0;
      r_img_len <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_led     <= 1'b0;
      r_gpio_i  <= '0;
    end else if (w_srst) begin
      r_kernel  <= '0;
      r_kptr    <= '0;
      r_img_len <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_led     <= 1'b0;
      r_gpio_i  <= '0;
    end else begin
      if (w_set_led) begin
        r_led <= 1'b1;
      end
      if (w_cmd && !w_busy) begin
        case (w_op)
          OP_KLOAD: begin
            r_kernel[r_kptr*COL_W +: COL_W] <= w_payload;
            r_kptr <= (r_kptr == 2'(M_LEN-1)) ? 2'd0 : r_kptr + 2'd1;
          end
          OP_SIZE: begin
            r_img_len <= w_payload[NB_ADDRESS-1:0];
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_led     <= 1'b0;
          end
          OP_ILOAD: begin
            r_wptr <= (r_wptr == r_img_len - ADDR_ONE) ? '0 : r_wptr + ADDR_ONE;
          end
          default: ;
        endcase
      end
      // Readback stays available while the engine runs.
      if (w_cmd && w_op == OP_DREQ) begin
        r_gpio_i <= {1'b1, {(GPIO_D-1-RAM_WIDTH){1'b0}}, r_res_ram[r_rptr]};
        r_rptr   <= (r_rptr == w_last_idx) ? '0 : r_rptr + ADDR_ONE;
      end
    end
  end

  // Image RAM: column write from ILOAD, one-cycle registered read for the window.
  always_ff @(posedge i_CLK) begin
    if (w_cmd && !w_busy && w_op == OP_ILOAD) begin
      r_img_ram[r_wptr] <= w_payload;
    end
    if (w_rd_en) begin
      r_rd_data <= r_img_ram[r_rd_idx];
    end
  end

  // Result RAM: one word per completed window.
  always_ff @(posedge i_CLK) begin
    if (w_mac_vld && w_busy && !w_srst) begin
      r_res_ram[r_wr_idx] <= w_mac_res;
    end
  end

  // Column window shift register and read/write indices; parked outside RUN.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_rd_vld  <= 1'b0;
      r_win_vld <= 1'b0;
      r_fill    <= '0;
      r_window  <= '0;
    end else if (w_srst || !w_busy) begin
      r_rd_idx  <= '0;
      r_wr_idx  <= '0;
      r_rd_vld  <= 1'b0;
      r_win_vld <= 1'b0;
      r_fill    <= '0;
    end else begin
      r_rd_vld  <= w_rd_en;
      r_win_vld <= 1'b0;
      if (w_rd_en) begin
        r_rd_idx <= r_rd_idx + ADDR_ONE;
      end
      if (r_rd_vld) begin
        // Newest column enters at the top slot; slot 0 is the oldest (c+0).
        r_window  <= {r_rd_data, r_window[WIN_W-1:COL_W]};
        r_win_vld <= (r_fill >= 2'(M_LEN-1));
        if (r_fill != 2'(M_LEN)) begin
          r_fill <= r_fill + 2'd1;
        end
      end
      if (w_mac_vld) begin
        r_wr_idx <= r_wr_idx + ADDR_ONE;
      end
    end
  end

  conv_mac u_mac (
    .i_clk    (i_CLK),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_srst | ~w_busy),
    .i_vld    (r_win_vld),
    .i_kernel (r_kernel),
    .i_window (r_window),
    .o_res    (w_mac_res),
    .o_vld    (w_mac_vld)
  );

  assign gpio_i_data_tri_i = r_gpio_i;
  assign o_led             = r_led;

endmodule

// File: tb/tb_micro_sim_top.sv
// tb_micro_sim_top: scenario tasks against an arithmetic convolution model.
module tb_micro_sim_top;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] gpio;
  logic [31:0] rdbk;
  logic        led;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] m_kernel [0:2];
  logic [23:0] m_img [0:1023];
  int m_kptr, m_len, m_wptr, m_rptr;

  micro_sim_top dut (
    .i_CLK             (clk),
    .i_rst_n           (rst_n),
    .gpio_o_data_tri_o (gpio),
    .gpio_i_data_tri_i (rdbk),
    .o_led             (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] model_res(input int c);
    int acc;
    acc = 0;
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0] kb;
        logic [7:0] pb;
        kb  = m_kernel[j][i*8 +: 8];
        pb  = m_img[c+j][i*8 +: 8];
        acc = acc + int'($signed(kb)) * int'(pb);
      end
    end
`ifdef MICRO_SIM_SAT_EN
    if (acc > 524287) acc = 524287;
    if (acc < -524287) acc = -524287;
`endif
    return 13'(acc >>> 7);
  endfunction

  function automatic void model_clear();
    for (int j = 0; j < 3; j++) m_kernel[j] = '0;
    m_kptr = 0; m_len = 0; m_wptr = 0; m_rptr = 0;
  endfunction

  task automatic drive(input logic [2:0] op, input logic vld, input logic [23:0] pl,
                       input logic srst, input int cycles);
    gpio = {op, vld, 3'b000, pl, srst};
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] op, input logic [23:0] pl);
    drive(op, 1'b0, pl, 1'b0, 3);
    drive(op, 1'b1, pl, 1'b0, 4);
    drive(op, 1'b0, pl, 1'b0, 3);
    case (op)
      OP_KLOAD: begin
        m_kernel[m_kptr] = pl;
        m_kptr = (m_kptr == 2) ? 0 : m_kptr + 1;
      end
      OP_SIZE: begin
        m_len = int'(pl[9:0]); m_wptr = 0; m_rptr = 0;
      end
      OP_ILOAD: begin
        m_img[m_wptr] = pl;
        m_wptr = (m_wptr == m_len - 1) ? 0 : m_wptr + 1;
      end
      default: ;
    endcase
  endtask

  task automatic dreq(output logic [31:0] got, output logic [31:0] exp);
    exp = {1'b1, 18'd0, model_res(m_rptr)};
    m_rptr = (m_rptr == m_len - 3) ? 0 : m_rptr + 1;
    send(OP_DREQ, 24'h0);
    got = rdbk;
  endtask

  task automatic run_conv(output int cyc, output bit ok);
    gpio = {OP_RUN, 1'b0, 3'b000, 24'h0, 1'b0};
    cyc = 0;
    while (!led && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    ok = led;
    drive(OP_KLOAD, 1'b0, 24'h0, 1'b0, 3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    gpio  = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL reset_led: got %b expected 0", led); end
    n_cmp++; if (rdbk !== 32'h0) begin n_err++; $display("FAIL reset_rdbk: got %h expected 00000000", rdbk); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    drive(3'b000, 1'b0, 24'h0, 1'b1, 5);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL srst_led: got %b expected 0", led); end
    drive(3'b000, 1'b0, 24'h0, 1'b0, 3);
    n_cmp++; if (rdbk !== 32'h0) begin n_err++; $display("FAIL srst_rdbk: got %h expected 00000000", rdbk); end
    model_clear();
  endtask

  task automatic test_basic_conv();
    int cyc; bit ok;
    for (int k = 0; k < 3; k++) send(OP_KLOAD, 24'h010101);
    send(OP_SIZE, 24'd5);
    for (int c = 0; c < 5; c++) send(OP_ILOAD, 24'h101010);
    run_conv(cyc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_run_done: timeout after %0d cycles", cyc); end
    n_cmp++; if (led !== 1'b1) begin n_err++; $display("FAIL basic_led: got %b expected 1", led); end
  endtask

  task automatic test_dreq_wrap();
    logic [31:0] got, exp;
    for (int r = 0; r < 4; r++) begin
      dreq(got, exp);
      n_cmp++;
      if (got !== 32'h80000001) begin
        n_err++; $display("FAIL dreq_wrap[%0d]: got %h expected 80000001", r, got);
      end
    end
  endtask

  task automatic test_negative();
    int cyc; bit ok;
    logic [31:0] got, exp;
    send(OP_KLOAD, 24'h0000FF);
    send(OP_KLOAD, 24'h000000);
    send(OP_KLOAD, 24'h000000);
    send(OP_SIZE, 24'd3);
    for (int c = 0; c < 3; c++) send(OP_ILOAD, 24'hFFFFFF);
    run_conv(cyc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL neg_run_done: timeout after %0d cycles", cyc); end
    dreq(got, exp);
    n_cmp++; if (got !== 32'h80001FFE) begin n_err++; $display("FAIL neg_trunc: got %h expected 80001ffe", got); end
  endtask

  task automatic test_short_image();
    int cyc; bit ok;
    logic [31:0] got, exp;
    send(OP_SIZE, 24'd2);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL short_size_clr_led: got %b expected 0", led); end
    run_conv(cyc, ok);
    // Two synchronizer stages ahead of the three-cycle completion.
    n_cmp++; if (!ok || cyc > 5) begin n_err++; $display("FAIL short_done_latency: got %0d cycles ok=%0b expected <=5", cyc, ok); end
    dreq(got, exp);
    n_cmp++; if (got !== 32'h80001FFE) begin n_err++; $display("FAIL short_no_write: got %h expected 80001ffe", got); end
  endtask

  task automatic test_random();
    int cyc; bit ok;
    logic [31:0] got, exp;
    for (int it = 0; it < 4; it++) begin
      int len, nk, ni;
      len = $urandom_range(3, 12);
      nk  = (it == 1) ? 4 : 3;
      ni  = (it == 2) ? len + 1 : len;
      for (int k = 0; k < nk; k++) send(OP_KLOAD, 24'($urandom));
      send(OP_SIZE, 24'(len));
      for (int c = 0; c < ni; c++) send(OP_ILOAD, 24'($urandom));
      run_conv(cyc, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_run_done[%0d]: timeout after %0d cycles", it, cyc); end
      for (int r = 0; r < len - 1; r++) begin
        dreq(got, exp);
        n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL rand_result[%0d][%0d]: got %h expected %h", it, r, got, exp);
        end
      end
    end
  endtask

  task automatic test_valid_edges();
    int cyc; bit ok;
    logic [31:0] e0, e1;
    for (int k = 0; k < 3; k++) send(OP_KLOAD, 24'h010101);
    send(OP_SIZE, 24'd5);
    for (int c = 0; c < 5; c++) send(OP_ILOAD, {3{8'(c * 20 + 1)}});
    run_conv(cyc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL edge_run_done: timeout after %0d cycles", cyc); end
    e0 = {1'b1, 18'd0, model_res(0)};
    e1 = {1'b1, 18'd0, model_res(1)};
    drive(OP_DREQ, 1'b0, 24'h0, 1'b0, 3);
    drive(OP_DREQ, 1'b1, 24'h0, 1'b0, 10);
    n_cmp++; if (rdbk !== e0) begin n_err++; $display("FAIL edge_rise: got %h expected %h", rdbk, e0); end
    drive(OP_DREQ, 1'b0, 24'h0, 1'b0, 10);
    n_cmp++; if (rdbk !== e0) begin n_err++; $display("FAIL edge_fall_ignored: got %h expected %h", rdbk, e0); end
    drive(OP_DREQ, 1'b1, 24'h0, 1'b0, 6);
    n_cmp++; if (rdbk !== e1) begin n_err++; $display("FAIL edge_second_rise: got %h expected %h", rdbk, e1); end
    drive(OP_DREQ, 1'b0, 24'h0, 1'b0, 3);
    m_rptr = 2;
  endtask

  task automatic test_soft_reset();
    int cyc; bit ok;
    logic [31:0] got, exp;
    send(OP_SIZE, 24'd600);
    drive(OP_RUN, 1'b0, 24'h0, 1'b0, 20);
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL srst_midrun_led: got %b expected 0", led); end
    drive(OP_RUN, 1'b0, 24'h0, 1'b1, 4);
    drive(OP_KLOAD, 1'b0, 24'h7F7F7F, 1'b1, 4);
    drive(OP_KLOAD, 1'b1, 24'h7F7F7F, 1'b1, 4);
    drive(OP_KLOAD, 1'b1, 24'h7F7F7F, 1'b0, 4);
    drive(OP_KLOAD, 1'b0, 24'h7F7F7F, 1'b0, 3);
    model_clear();
    n_cmp++; if (led !== 1'b0) begin n_err++; $display("FAIL srst_after_led: got %b expected 0", led); end
    n_cmp++; if (rdbk !== 32'h0) begin n_err++; $display("FAIL srst_after_rdbk: got %h expected 00000000", rdbk); end
    send(OP_SIZE, 24'd3);
    for (int c = 0; c < 3; c++) send(OP_ILOAD, 24'($urandom) | 24'h010101);
    run_conv(cyc, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL srst_recover_done: timeout after %0d cycles", cyc); end
    dreq(got, exp);
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL srst_kernel_cleared: got %h expected %h", got, exp); end
  endtask

  initial begin
    rst_n = 1'b0;
    gpio  = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic_conv();
    test_dreq_wrap();
    test_negative();
    test_short_image();
    test_random();
    test_valid_edges();
    test_soft_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
